// File: rtl/s2f_gray_count_rx.sv
// s2f_gray_count_rx: fast-domain (clk2) receiver for a Gray-coded counter
// launched from the slow clk1 domain. It synchronises the count, converts it
// to binary, publishes validated updates, and flags illegal jumps.
module s2f_gray_count_rx #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_STEP    = 1
) (
  input  logic             clk2,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count_out,
  output logic             count_valid,
  output logic             update,
  output logic [WIDTH-1:0] step,
  output logic             err
);

  localparam int CW = $clog2(SYNC_STAGES + 1);
  localparam logic [WIDTH-1:0] MAX_DELTA  = WIDTH'(MAX_STEP);
  localparam logic [CW-1:0]    FLUSH_LOAD = CW'(SYNC_STAGES);

  typedef enum logic [1:0] {FLUSH, SETTLE, TRACK} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    flush_q, flush_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] bin_now;
  logic [WIDTH-1:0] delta;
  logic [WIDTH-1:0] samp_q, samp_d;
  logic [WIDTH-1:0] count_d, step_d;
  logic             valid_d, update_d, err_d;
  logic             acc;

  // Plain flop chain for the asynchronous Gray input; no logic between stages.
  always_ff @(posedge clk2) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Gray-to-binary of the last synchroniser stage: running XOR from the MSB down.
  always_comb begin
    bin_now = '0;
    acc     = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      acc                    = acc ^ sync_q[SYNC_STAGES-1][WIDTH-1-i];
      bin_now[WIDTH-1-i]     = acc;
    end
  end

  // Forward distance from the last accepted value; modular so wrap is legal.
  assign delta = bin_now - count_out;

  // Next-state and next-output logic for flush / settle / track.
  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    samp_d   = samp_q;
    count_d  = count_out;
    step_d   = step;
    valid_d  = count_valid;
    update_d = 1'b0;
    err_d    = err;
    if (clr_err) err_d = 1'b0;
    unique case (state_q)
      FLUSH: begin
        valid_d = 1'b0;
        if (flush_q == '0) begin
          state_d = SETTLE;
          samp_d  = bin_now;
        end else begin
          flush_d = flush_q - CW'(1);
        end
      end
      SETTLE: begin
        valid_d = 1'b0;
        samp_d  = bin_now;
        if (bin_now == samp_q) begin
          count_d = bin_now;
          valid_d = 1'b1;
          step_d  = '0;
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (delta != '0) begin
          if (delta <= MAX_DELTA) begin
            count_d  = bin_now;
            step_d   = delta;
            update_d = 1'b1;
          end else begin
            // illegal jump: set overrides a same-edge clr_err
            err_d   = 1'b1;
            valid_d = 1'b0;
            samp_d  = bin_now;
            state_d = SETTLE;
          end
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  // State and output registers; reset overrides everything on its edge.
  always_ff @(posedge clk2) begin
    if (reset) begin
      state_q     <= FLUSH;
      flush_q     <= FLUSH_LOAD;
      samp_q      <= '0;
      count_out   <= '0;
      step        <= '0;
      count_valid <= 1'b0;
      update      <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      samp_q      <= samp_d;
      count_out   <= count_d;
      step        <= step_d;
      count_valid <= valid_d;
      update      <= update_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_s2f_gray_count_rx.sv
// tb_s2f_gray_count_rx: self-checking bench with two receivers (MAX_STEP=1
// and MAX_STEP=2) on one clk2; update events are scoreboarded.
module tb_s2f_gray_count_rx;

  logic       clk2 = 1'b0;
  logic       reset;
  logic [3:0] ga, gb;
  logic       clr_a, clr_b;
  logic [3:0] cnt_a, stp_a, cnt_b, stp_b;
  logic       val_a, upd_a, err_a, val_b, upd_b, err_b;

  always #5 clk2 = ~clk2;

  s2f_gray_count_rx #(.WIDTH(4), .SYNC_STAGES(2), .MAX_STEP(1)) dut_a (
    .clk2(clk2), .reset(reset), .gray_in(ga), .clr_err(clr_a),
    .count_out(cnt_a), .count_valid(val_a), .update(upd_a), .step(stp_a), .err(err_a)
  );

  s2f_gray_count_rx #(.WIDTH(4), .SYNC_STAGES(2), .MAX_STEP(2)) dut_b (
    .clk2(clk2), .reset(reset), .gray_in(gb), .clr_err(clr_b),
    .count_out(cnt_b), .count_valid(val_b), .update(upd_b), .step(stp_b), .err(err_b)
  );

  typedef struct {
    int         id;
    logic [3:0] cnt;
    logic [3:0] stp;
  } ev_t;

  typedef struct {
    logic [3:0] val;
    int         hold;
    int         exp_cnt;
    int         exp_valid;
    int         exp_err;
    int         exp_step;
  } vec_t;

  ev_t  exp_q[$];
  ev_t  got_q[$];
  vec_t tbl[13];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [3:0] gray(input int v);
    logic [3:0] b;
    b = 4'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk2);
    #1;
  endtask

  // Compare every observed update event against the expected list, in order.
  task automatic sb_drain(input string name);
    ev_t e, g;
    check({name, " update count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({name, " update id"}, g.id, e.id);
      check({name, " update count_out"}, int'(g.cnt), int'(e.cnt));
      check({name, " update step"}, int'(g.stp), int'(e.stp));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // Log every cycle in which either receiver pulses update.
  always @(negedge clk2) begin
    if (reset === 1'b0) begin
      if (upd_a) got_q.push_back('{0, cnt_a, stp_a});
      if (upd_b) got_q.push_back('{1, cnt_b, stp_b});
    end
  end

  initial begin
    for (int i = 0; i < 13; i++) begin
      tbl[i].val       = 4'((7 + i) % 16);
      tbl[i].hold      = 4;
      tbl[i].exp_cnt   = (7 + i) % 16;
      tbl[i].exp_valid = 1;
      tbl[i].exp_err   = 0;
      tbl[i].exp_step  = 1;
    end

    reset = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    ga = gray(5); gb = gray(0);
    tick(3);
    check("reset count_out", int'(cnt_a), 0);
    check("reset count_valid", int'(val_a), 0);
    check("reset update", int'(upd_a), 0);
    check("reset err", int'(err_a), 0);
    check("reset step", int'(stp_a), 0);

    // Acquisition from reset release
    reset = 1'b0;
    for (int i = 0; i < 6 && val_a !== 1'b1; i++) tick(1);
    check("acquire valid", int'(val_a), 1);
    check("acquire count_out", int'(cnt_a), 5);
    check("acquire step", int'(stp_a), 0);
    check("acquire err", int'(err_a), 0);
    check("acquire b valid", int'(val_b), 1);
    sb_drain("acquire");

    // Single legal step: update on the third edge, for one cycle
    ga = gray(6);
    exp_q.push_back('{0, 4'd6, 4'd1});
    tick(1); check("lat edge1 update", int'(upd_a), 0);
    tick(1); check("lat edge2 update", int'(upd_a), 0);
    tick(1); check("lat edge3 update", int'(upd_a), 1);
    check("lat edge3 count_out", int'(cnt_a), 6);
    check("lat edge3 step", int'(stp_a), 1);
    tick(1); check("lat edge4 update", int'(upd_a), 0);
    sb_drain("latency");

    // Table: walk 7..15, wrap to 0, on to 3
    for (int i = 0; i < 13; i++) begin
      ga = gray(int'(tbl[i].val));
      exp_q.push_back('{0, tbl[i].val, 4'(tbl[i].exp_step)});
      tick(tbl[i].hold);
      check($sformatf("tbl[%0d] count_out", i), int'(cnt_a), tbl[i].exp_cnt);
      check($sformatf("tbl[%0d] valid", i), int'(val_a), tbl[i].exp_valid);
      check($sformatf("tbl[%0d] err", i), int'(err_a), tbl[i].exp_err);
      check($sformatf("tbl[%0d] step", i), int'(stp_a), tbl[i].exp_step);
    end
    sb_drain("walk");

    // Illegal jump 3 -> 9 with MAX_STEP=1
    ga = gray(9);
    tick(2);
    check("jump edge2 err", int'(err_a), 0);
    tick(1);
    check("jump err", int'(err_a), 1);
    check("jump valid", int'(val_a), 0);
    check("jump count_out hold", int'(cnt_a), 3);
    check("jump update", int'(upd_a), 0);
    tick(1);
    check("resync valid", int'(val_a), 1);
    check("resync count_out", int'(cnt_a), 9);
    check("resync step", int'(stp_a), 0);
    check("resync err sticky", int'(err_a), 1);
    tick(2);
    check("err still sticky", int'(err_a), 1);
    sb_drain("resync");
    clr_a = 1'b1; tick(1); clr_a = 1'b0;
    check("clr_err clears", int'(err_a), 0);

    // MAX_STEP=2: steps of two are legal
    gb = gray(2); exp_q.push_back('{1, 4'd2, 4'd2}); tick(4);
    gb = gray(4); exp_q.push_back('{1, 4'd4, 4'd2}); tick(4);
    gb = gray(6); exp_q.push_back('{1, 4'd6, 4'd2}); tick(4);
    check("b count_out", int'(cnt_b), 6);
    check("b step", int'(stp_b), 2);
    check("b err", int'(err_b), 0);
    sb_drain("step2");

    // Illegal jump and clr_err on the same edge: set wins
    gb = gray(12);
    tick(2);
    clr_b = 1'b1; tick(1); clr_b = 1'b0;
    check("b set-wins err", int'(err_b), 1);
    check("b jump valid", int'(val_b), 0);
    check("b jump count_out", int'(cnt_b), 6);
    tick(1);
    check("b resync count_out", int'(cnt_b), 12);
    check("b resync valid", int'(val_b), 1);
    clr_b = 1'b1; tick(1); clr_b = 1'b0;
    check("b clr_err", int'(err_b), 0);
    sb_drain("b jump");

    // Reset mid-TRACK with count_out=9
    check("pre-reset count_out", int'(cnt_a), 9);
    reset = 1'b1; tick(1);
    check("midreset count_out", int'(cnt_a), 0);
    check("midreset valid", int'(val_a), 0);
    check("midreset err", int'(err_a), 0);
    check("midreset update", int'(upd_a), 0);
    check("midreset b count_out", int'(cnt_b), 0);
    reset = 1'b0;
    for (int i = 0; i < 6 && val_a !== 1'b1; i++) tick(1);
    check("reacquire valid", int'(val_a), 1);
    check("reacquire count_out", int'(cnt_a), 9);
    tick(2);
    sb_drain("reacquire");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
